// File: rtl/gf180mcu_fd_sc_mcu9t5v0__oain1_dglt_pkg.sv
// Shared constants, counter-width helper and parameter range-check macro
// for the deglitched multi-channel OAI block.
`ifndef GF180_OAIN1_DGLT_PKG_SV
`define GF180_OAIN1_DGLT_PKG_SV

// Emits an elaboration-time error when a parameter lies outside [lo, hi].
`define OAIN_RANGE_CHK(lbl, name, val, lo, hi) \
   if (((val) < (lo)) || ((val) > (hi))) begin : lbl \
      $error("%s=%0d outside legal range %0d..%0d", name, (val), (lo), (hi)); \
   end

package gf180mcu_fd_sc_mcu9t5v0__oain1_dglt_pkg;

   localparam logic ZN_RST  = 1'b1;
   localparam logic CHG_RST = 1'b0;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int x = v - 1; x > 0; x = x >>> 1) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

`endif

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dglt_ch.sv
// One deglitch channel: counts consecutive enabled mismatches between raw
// and the registered output, and commits raw after DGLT of them.
module gf180mcu_fd_sc_mcu9t5v0__dglt_ch
   import gf180mcu_fd_sc_mcu9t5v0__oain1_dglt_pkg::*;
#(
   parameter int DGLT = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,
   input  logic raw_i,
   output logic zn_o,
   output logic chg_o
);

   `OAIN_RANGE_CHK(g_chk_dglt, "DGLT", DGLT, 1, 255)

   localparam int            CW       = clog2(DGLT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DGLT - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          zn_q, zn_d;
   logic          chg_q, chg_d;

   // A raw value that is neither equal nor unequal (X/Z) falls to the final
   // else and clears the count, so unknowns never reach ZN.
   always_comb begin
      cnt_d = cnt_q;
      zn_d  = zn_q;
      chg_d = 1'b0;
      if (en_i) begin
         if (raw_i == zn_q) begin
            cnt_d = '0;
         end else if (raw_i != zn_q) begin
            if (cnt_q == CNT_LAST) begin
               zn_d  = raw_i;
               cnt_d = '0;
               chg_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end else begin
            cnt_d = '0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         zn_q  <= ZN_RST;
         chg_q <= CHG_RST;
      end else begin
         cnt_q <= cnt_d;
         zn_q  <= zn_d;
         chg_q <= chg_d;
      end
   end

   assign zn_o  = zn_q;
   assign chg_o = chg_q;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__oain1_dglt.sv
// NCH-channel registered OAI (ZN = !(|A_i & B_i)) with per-channel deglitch
// and a one-cycle CHG pulse on every accepted output transition.
module gf180mcu_fd_sc_mcu9t5v0__oain1_dglt
   import gf180mcu_fd_sc_mcu9t5v0__oain1_dglt_pkg::*;
#(
   parameter int NA   = 3,
   parameter int NCH  = 2,
   parameter int DGLT = 2
) (
`ifdef USE_POWER_PINS
   inout  wire                 VDD,
   inout  wire                 VSS,
`endif
   input  logic                CLK,
   input  logic                RN,
   input  logic                EN,
   input  logic [NCH*NA-1:0]   A,
   input  logic [NCH-1:0]      B,
   output logic [NCH-1:0]      ZN,
   output logic [NCH-1:0]      CHG
);

   `OAIN_RANGE_CHK(g_chk_na,  "NA",  NA,  1, 8)
   `OAIN_RANGE_CHK(g_chk_nch, "NCH", NCH, 1, 32)

   logic [NCH-1:0] raw;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      assign raw[i] = ~((|A[i*NA +: NA]) & B[i]);

      gf180mcu_fd_sc_mcu9t5v0__dglt_ch #(
         .DGLT (DGLT)
      ) u_ch (
         .clk_i  (CLK),
         .rst_ni (RN),
         .en_i   (EN),
         .raw_i  (raw[i]),
         .zn_o   (ZN[i]),
         .chg_o  (CHG[i])
      );
   end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__oain1_dglt.sv
// Directed and randomized bench for the deglitched OAI block, with a
// sample-history reference model (DGLT=3/NCH=2 and DGLT=1/NCH=4 instances).
module tb_gf180mcu_fd_sc_mcu9t5v0__oain1_dglt;

   logic        CLK = 1'b0;
   logic        RN, EN, EN2;
   logic [5:0]  A;
   logic [1:0]  B, ZN, CHG;
   logic [11:0] A2;
   logic [3:0]  B2, ZN2, CHG2;

   int checks = 0;
   int errors = 0;
   int chg_cnt;
   logic bs;

   bit m1_zn[2];
   bit m1_chg[2];
   bit m1_h[2][$];
   bit m2_zn[4];
   bit m2_chg[4];
   bit m2_h[4][$];

   gf180mcu_fd_sc_mcu9t5v0__oain1_dglt #(.NA(3), .NCH(2), .DGLT(3)) dut (
      .CLK (CLK), .RN (RN), .EN (EN), .A (A), .B (B), .ZN (ZN), .CHG (CHG)
   );

   gf180mcu_fd_sc_mcu9t5v0__oain1_dglt #(.NA(3), .NCH(4), .DGLT(1)) dut2 (
      .CLK (CLK), .RN (RN), .EN (EN2), .A (A2), .B (B2), .ZN (ZN2), .CHG (CHG2)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench did not finish");
   end

   function automatic bit raw_of(input logic [2:0] a, input logic b);
      return !((a != 3'b000) && (b == 1'b1));
   endfunction

   // Length of the trailing run of samples that disagree with the output.
   function automatic int trailing(input bit q[$], input bit zn);
      int n;
      n = 0;
      for (int k = q.size() - 1; k >= 0; k--) begin
         if (q[k] == zn) break;
         n++;
      end
      return n;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         m1_zn[c] = 1'b1; m1_chg[c] = 1'b0; m1_h[c].delete();
      end
      for (int c = 0; c < 4; c++) begin
         m2_zn[c] = 1'b1; m2_chg[c] = 1'b0; m2_h[c].delete();
      end
   endtask

   task automatic model_edge();
      if (RN) begin
         for (int c = 0; c < 2; c++) begin
            bit r;
            int run;
            m1_chg[c] = 1'b0;
            if (EN) begin
               r = raw_of(A[c*3 +: 3], B[c]);
               m1_h[c].push_back(r);
               run = trailing(m1_h[c], m1_zn[c]);
               if (run == 0) m1_h[c].delete();
               if (run >= 3) begin
                  m1_zn[c] = r; m1_chg[c] = 1'b1; m1_h[c].delete();
               end
            end
         end
         for (int c = 0; c < 4; c++) begin
            bit r;
            int run;
            m2_chg[c] = 1'b0;
            if (EN2) begin
               r = raw_of(A2[c*3 +: 3], B2[c]);
               m2_h[c].push_back(r);
               run = trailing(m2_h[c], m2_zn[c]);
               if (run == 0) m2_h[c].delete();
               if (run >= 1) begin
                  m2_zn[c] = r; m2_chg[c] = 1'b1; m2_h[c].delete();
               end
            end
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [1:0] z1, c1;
      logic [3:0] z2, c2;
      for (int c = 0; c < 2; c++) begin z1[c] = m1_zn[c]; c1[c] = m1_chg[c]; end
      for (int c = 0; c < 4; c++) begin z2[c] = m2_zn[c]; c2[c] = m2_chg[c]; end
      chk({tag, "_zn"},   32'(ZN),   32'(z1));
      chk({tag, "_chg"},  32'(CHG),  32'(c1));
      chk({tag, "_zn2"},  32'(ZN2),  32'(z2));
      chk({tag, "_chg2"}, 32'(CHG2), 32'(c2));
   endtask

   task automatic tick(input string tag);
      @(posedge CLK);
      model_edge();
      #1;
      check_all(tag);
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic rst_pulse();
      RN = 1'b0;
      #1;
      model_reset();
      check_all("rst_pulse");
      chk("rst_pulse_zn_const", 32'(ZN), 32'h3);
      RN = 1'b1;
   endtask

   task automatic idle_inputs();
      A = '0; B = '0; A2 = '0; B2 = '0; EN = 1'b1; EN2 = 1'b1;
   endtask

   initial begin
      RN = 1'b1; EN = 1'b1; EN2 = 1'b1;
      A = 6'($urandom); B = 2'($urandom); A2 = 12'($urandom); B2 = 4'($urandom);
      #2 RN = 1'b0;
      model_reset();
      #1 check_all("rst_async");
      chk("rst_zn", 32'(ZN), 32'h3);
      chk("rst_chg", 32'(CHG), 32'h0);
      tick("rst_held");
      idle_inputs();
      RN = 1'b1;
      for (int i = 0; i < 5; i++) tick("idle");
      chk("idle_zn", 32'(ZN), 32'h3);

      // Stable transition on ch0
      rst_pulse();
      A = 6'b000_010; B = 2'b01;
      tick("st_e0"); chk("st_e0_zn", 32'(ZN), 32'h3);
      tick("st_e1"); chk("st_e1_zn", 32'(ZN), 32'h3);
      tick("st_e2"); chk("st_e2_zn", 32'(ZN), 32'h2); chk("st_e2_chg", 32'(CHG), 32'h1);
      tick("st_e3"); chk("st_e3_chg", 32'(CHG), 32'h0); chk("st_e3_zn", 32'(ZN), 32'h2);

      // Glitch rejection: low 2, high 1, low 3
      idle_inputs(); rst_pulse();
      chg_cnt = 0;
      A = 6'b000_100; B = 2'b01;
      tick("gl_a"); chg_cnt += int'(CHG[0]);
      tick("gl_b"); chg_cnt += int'(CHG[0]);
      B = 2'b00;
      tick("gl_c"); chg_cnt += int'(CHG[0]);
      B = 2'b01;
      tick("gl_d"); chg_cnt += int'(CHG[0]);
      tick("gl_e"); chg_cnt += int'(CHG[0]); chk("gl_e_zn", 32'(ZN), 32'h3);
      tick("gl_f"); chg_cnt += int'(CHG[0]); chk("gl_f_zn", 32'(ZN), 32'h2);
      tick("gl_g"); chg_cnt += int'(CHG[0]);
      chk("gl_pulses", 32'(chg_cnt), 32'd1);

      // EN pause keeps the partial count
      idle_inputs(); rst_pulse();
      A = 6'b000_001; B = 2'b01;
      tick("en_a"); tick("en_b");
      EN = 1'b0;
      for (int i = 0; i < 4; i++) tick("en_pause");
      chk("en_pause_zn", 32'(ZN), 32'h3);
      EN = 1'b1;
      tick("en_resume"); chk("en_resume_zn", 32'(ZN), 32'h2); chk("en_resume_chg", 32'(CHG), 32'h1);

      // EN pause with mismatch removed: count clears on resume
      idle_inputs(); rst_pulse();
      A = 6'b000_001; B = 2'b01;
      tick("enc_a"); tick("enc_b");
      EN = 1'b0; tick("enc_p0");
      B = 2'b00;
      for (int i = 0; i < 3; i++) tick("enc_p");
      EN = 1'b1; tick("enc_clr"); chk("enc_clr_zn", 32'(ZN), 32'h3);
      B = 2'b01;
      tick("enc_c"); tick("enc_d"); chk("enc_d_zn", 32'(ZN), 32'h3);
      tick("enc_e"); chk("enc_e_zn", 32'(ZN), 32'h2);

      // Reset mid-count discards the partial count
      idle_inputs(); rst_pulse();
      A = 6'b000_011; B = 2'b01;
      tick("rm_a"); tick("rm_b");
      rst_pulse();
      tick("rm_c"); tick("rm_d"); chk("rm_d_zn", 32'(ZN), 32'h3);
      tick("rm_e"); chk("rm_e_zn", 32'(ZN), 32'h2);

      // DGLT=1 instance: toggling ch2 B follows each edge
      idle_inputs(); rst_pulse();
      A2 = 12'b000_111_000_000; B2 = 4'b0100;
      for (int i = 0; i < 8; i++) begin
         bs = B2[2];
         tick("d1");
         chk("d1_zn2", 32'(ZN2), 32'({1'b1, ~bs, 2'b11}));
         chk("d1_chg2", 32'(CHG2), 32'h4);
         B2[2] = ~B2[2];
      end

      // Randomized traffic against the history model
      idle_inputs(); rst_pulse();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(3) == 0) A  = 6'($urandom);
         if ($urandom_range(3) == 0) B  = 2'($urandom);
         if ($urandom_range(2) == 0) A2 = 12'($urandom);
         if ($urandom_range(2) == 0) B2 = 4'($urandom);
         EN  = ($urandom_range(4) != 0);
         EN2 = ($urandom_range(4) != 0);
         if ($urandom_range(79) == 0) rst_pulse();
         tick("rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
